// File: rtl/llc_input_arbiter.sv
// LLC front-end scheduler: admits one transaction at a time from rsp, rst_tb, req and dma channels.
// Optional starvation override for the low class is compiled in with `define LLC_ARB_STARVE_EN.
module llc_input_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rsp_valid_i,
    output logic       rsp_ready_o,
    input  logic       rst_tb_valid_i,
    output logic       rst_tb_ready_o,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       dma_valid_i,
    output logic       dma_ready_o,
    input  logic       req_blocked_i,
    input  logic       dma_blocked_i,
    input  logic       pipe_done_i,
    output logic       grant_valid_o,
    output logic [1:0] grant_src_o,
    output logic       busy_o,
    output logic       starved_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic [1:0] grant_src_q, grant_src_d;
    logic       grant_valid_q, grant_valid_d;

    logic       rsp_elig, rst_elig, req_elig, dma_elig;
    logic       low_elig;
    logic       low_pick_dma;
    logic [1:0] low_oh;
    logic [3:0] win_oh;
    logic       starved_w;

    // Limits outside 1..15 cannot be represented by the 4-bit counter.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

    assign rsp_elig = rsp_valid_i;
    assign rst_elig = rst_tb_valid_i;
    assign req_elig = req_valid_i & ~req_blocked_i;
    assign dma_elig = dma_valid_i & ~dma_blocked_i;
    assign low_elig = req_elig | dma_elig;

`ifdef LLC_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starved_w = (starve_cnt_q == LIMIT);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (win_oh[2] | win_oh[3]) begin
            starve_cnt_d = 4'd0;
        end else if ((win_oh[0] | win_oh[1]) && low_elig && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starved_w = 1'b0;
`endif

    // Winner selection; rr_last_q == 1 means dma went last, so req wins a tie.
    always_comb begin
        low_pick_dma = dma_elig & (~req_elig | ~rr_last_q);
        low_oh       = {low_pick_dma, low_elig & ~low_pick_dma};
        win_oh       = 4'b0000;
        if (state_q == IDLE) begin
            if (starved_w && low_elig) begin
                win_oh = {low_oh, 2'b00};
            end else if (rsp_elig) begin
                win_oh = 4'b0001;
            end else if (rst_elig) begin
                win_oh = 4'b0010;
            end else begin
                win_oh = {low_oh, 2'b00};
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = 1'b0;
        grant_src_d   = grant_src_q;
        rr_last_d     = rr_last_q;
        case (state_q)
            IDLE: begin
                if (|win_oh) begin
                    state_d       = BUSY;
                    grant_valid_d = 1'b1;
                    if (win_oh[3]) begin
                        grant_src_d = 2'd3;
                        rr_last_d   = 1'b1;
                    end else if (win_oh[2]) begin
                        grant_src_d = 2'd2;
                        rr_last_d   = 1'b0;
                    end else if (win_oh[1]) begin
                        grant_src_d = 2'd1;
                    end else begin
                        grant_src_d = 2'd0;
                    end
                end
            end
            BUSY: begin
                if (pipe_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            grant_src_q   <= 2'd0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            grant_src_q   <= grant_src_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    // Readies are gated by rst so nothing handshakes while reset is held.
    assign rsp_ready_o    = win_oh[0] & rst;
    assign rst_tb_ready_o = win_oh[1] & rst;
    assign req_ready_o    = win_oh[2] & rst;
    assign dma_ready_o    = win_oh[3] & rst;

    assign grant_valid_o = grant_valid_q;
    assign grant_src_o   = grant_src_q;
    assign busy_o        = (state_q == BUSY);
    assign starved_o     = starved_w;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Self-checking bench for llc_input_arbiter: directed scenarios plus random traffic against a reference model.
// Honours `define LLC_ARB_STARVE_EN in the expected behaviour.
module tb_llc_input_arbiter;

    localparam int LIMIT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid_v;
    logic       req_blk, dma_blk, pipe_done;
    logic       rsp_ready, rst_tb_ready, req_ready, dma_ready;
    logic       grant_valid, busy, starved;
    logic [1:0] grant_src;
    logic [3:0] readies;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit         m_busy;
    bit         m_rr_last;
    bit         m_gv;
    logic [1:0] m_src;
    int         m_cnt;
    int         dut_log[$];

    always #5 clk = ~clk;

    llc_input_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .rsp_valid_i    (valid_v[0]),
        .rsp_ready_o    (rsp_ready),
        .rst_tb_valid_i (valid_v[1]),
        .rst_tb_ready_o (rst_tb_ready),
        .req_valid_i    (valid_v[2]),
        .req_ready_o    (req_ready),
        .dma_valid_i    (valid_v[3]),
        .dma_ready_o    (dma_ready),
        .req_blocked_i  (req_blk),
        .dma_blocked_i  (dma_blk),
        .pipe_done_i    (pipe_done),
        .grant_valid_o  (grant_valid),
        .grant_src_o    (grant_src),
        .busy_o         (busy),
        .starved_o      (starved)
    );

    assign readies = {dma_ready, req_ready, rst_tb_ready, rsp_ready};

    function automatic bit modelStarved();
`ifdef LLC_ARB_STARVE_EN
        return (m_cnt == LIMIT);
`else
        return 1'b0;
`endif
    endfunction

    // Returns the channel index admitted this cycle, or -1.
    function automatic int pickWinner(input logic [3:0] v, input logic rb, input logic db);
        bit e_req;
        bit e_dma;
        int low;
        e_req = v[2] && !rb;
        e_dma = v[3] && !db;
        if (m_busy) return -1;
        if (e_req && e_dma) low = m_rr_last ? 2 : 3;
        else if (e_req)     low = 2;
        else if (e_dma)     low = 3;
        else                low = -1;
        if (modelStarved() && low >= 0) return low;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return low;
    endfunction

    task automatic modelReset();
        m_busy    = 1'b0;
        m_rr_last = 1'b1;
        m_gv      = 1'b0;
        m_src     = 2'd0;
        m_cnt     = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkPostEdge();
        checkOutput("busy", {3'b0, busy}, {3'b0, m_busy});
        checkOutput("grant_valid", {3'b0, grant_valid}, {3'b0, m_gv});
        checkOutput("grant_src", {2'b0, grant_src}, {2'b0, m_src});
        checkOutput("starved", {3'b0, starved}, {3'b0, modelStarved()});
    endtask

    // One clock cycle: drive inputs, check readies, clock, advance model, check registered outputs.
    task automatic applyStimulus(input logic [3:0] v, input logic rb, input logic db,
                                 input logic pd, output int w);
        bit low_e;
        @(negedge clk);
        valid_v   = v;
        req_blk   = rb;
        dma_blk   = db;
        pipe_done = pd;
        #1;
        w = pickWinner(v, rb, db);
        low_e = (v[2] && !rb) || (v[3] && !db);
        checkOutput("ready", readies, (w >= 0) ? 4'(1 << w) : 4'b0000);
        @(posedge clk);
        #1;
        if (m_busy) begin
            m_gv = 1'b0;
            if (pd) m_busy = 1'b0;
        end else if (w >= 0) begin
            m_busy = 1'b1;
            m_gv   = 1'b1;
            m_src  = 2'(w);
            if (w >= 2) begin
                m_rr_last = (w == 3);
                m_cnt     = 0;
            end else if (low_e && m_cnt < LIMIT) begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_gv = 1'b0;
        end
        if (grant_valid === 1'b1) dut_log.push_back(int'(grant_src));
        checkPostEdge();
    endtask

    task automatic checkSeq(input string tag, input int exp[$]);
        checkOutput({tag, "_count"}, 4'(dut_log.size()), 4'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++) begin
            checkOutput(tag, 4'(dut_log[i]), 4'(exp[i]));
        end
    endtask

    // Holds a valid pattern for one admission, then completes it; granted channel drops its valid if asked.
    task automatic admitAndComplete(inout logic [3:0] v, input logic rb, input logic db, input bit drop);
        int w;
        int w2;
        applyStimulus(v, rb, db, 1'b0, w);
        if (drop && w >= 0) v[w] = 1'b0;
        applyStimulus(v, rb, db, 1'b1, w2);
    endtask

    initial begin
        logic [3:0] v;
        int         w;
        int         exp_q[$];

        rst       = 1'b0;
        valid_v   = 4'b1111;
        req_blk   = 1'b0;
        dma_blk   = 1'b0;
        pipe_done = 1'b0;
        modelReset();
        #23;
        checkOutput("reset_busy", {3'b0, busy}, 4'd0);
        checkOutput("reset_grant_valid", {3'b0, grant_valid}, 4'd0);
        checkOutput("reset_grant_src", {2'b0, grant_src}, 4'd0);
        checkOutput("reset_starved", {3'b0, starved}, 4'd0);
        checkOutput("reset_readies", readies, 4'd0);
        @(negedge clk);
        valid_v = 4'b0000;
        rst     = 1'b1;

        // Single rsp admission, busy held until after pipe_done
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, w);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, w);
        checkOutput("rsp_grant_src", {2'b0, grant_src}, 4'd0);
        checkOutput("rsp_grant_valid", {3'b0, grant_valid}, 4'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, w);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, w);
        checkOutput("rsp_busy_hold", {3'b0, busy}, 4'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, w);
        checkOutput("rsp_busy_clear", {3'b0, busy}, 4'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, w);

        // All four channels valid: strict priority order
        dut_log.delete();
        v = 4'b1111;
        repeat (4) admitAndComplete(v, 1'b0, 1'b0, 1'b1);
        exp_q = '{0, 1, 2, 3};
        checkSeq("seq_all4", exp_q);

        // req and dma held: round-robin alternation
        dut_log.delete();
        v = 4'b1100;
        repeat (4) admitAndComplete(v, 1'b0, 1'b0, 1'b0);
        exp_q = '{2, 3, 2, 3};
        checkSeq("seq_rr", exp_q);

        // req blocked: dma wins, then req after the block drops
        dut_log.delete();
        v = 4'b1100;
        admitAndComplete(v, 1'b1, 1'b0, 1'b0);
        admitAndComplete(v, 1'b0, 1'b0, 1'b0);
        exp_q = '{3, 2};
        checkSeq("seq_blocked", exp_q);

        // Block toggled while busy must not change anything
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, w);
        applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, w);
        applyStimulus(4'b0100, 1'b0, 1'b1, 1'b1, w);

        // rsp continuously valid alongside req
        dut_log.delete();
        v = 4'b0101;
        repeat (5) admitAndComplete(v, 1'b0, 1'b0, 1'b0);
`ifdef LLC_ARB_STARVE_EN
        exp_q = '{0, 0, 0, 2, 0};
`else
        exp_q = '{0, 0, 0, 0, 0};
`endif
        checkSeq("seq_starve", exp_q);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, w);

        // Reset mid-transaction during a req admission
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, w);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, w);
        @(negedge clk);
        valid_v = 4'b0001;
        rst     = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_busy", {3'b0, busy}, 4'd0);
        checkOutput("midreset_readies", readies, 4'd0);
        checkOutput("midreset_grant_valid", {3'b0, grant_valid}, 4'd0);
        checkOutput("midreset_grant_src", {2'b0, grant_src}, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("midreset_hold_busy", {3'b0, busy}, 4'd0);
        rst = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, w);
        checkOutput("postreset_rsp_src", {2'b0, grant_src}, 4'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, w);
        dut_log.delete();
        v = 4'b1100;
        admitAndComplete(v, 1'b0, 1'b0, 1'b0);
        exp_q = '{2};
        checkSeq("seq_rr_after_reset", exp_q);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rv;
            logic       rb;
            logic       db;
            logic       pd;
            rv = 4'($urandom);
            rb = ($urandom_range(0, 3) == 0);
            db = ($urandom_range(0, 3) == 0);
            pd = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            applyStimulus(rv, rb, db, pd, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
